// File: rtl/ro_sched_pkg.sv
// Shared types and default sizing for the ring-oscillator scan scheduler.
package ro_sched_pkg;

  localparam int N_RO_DEFAULT          = 4;
  localparam int SETTLE_CYCLES_DEFAULT = 16;
  localparam int WINDOW_CYCLES_DEFAULT = 1024;
  localparam int CNT_W_DEFAULT         = 24;
  localparam int TIMER_W               = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_GATE,
    ST_CAPTURE,
    ST_REPORT,
    ST_NEXT
  } state_e;

endpackage

// File: rtl/ro_next_index.sv
// Finds the lowest set bit of mask strictly above idx (purely combinational).
module ro_next_index #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     mask,
  input  logic [IDX_W-1:0] idx,
  output logic             valid,
  output logic [IDX_W-1:0] next_idx
);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    valid    = 1'b0;
    next_idx = '0;
    // Walk downward so the last hit, and therefore the winner, is the lowest bit.
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i] && (IDX_W'(i) > idx)) begin
        valid    = 1'b1;
        next_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/ro_scan_scheduler.sv
// Sequences a shared edge counter across masked ring oscillators: settle, gate,
// capture, then hand each count to the consumer before moving on.
module ro_scan_scheduler
  import ro_sched_pkg::*;
#(
  parameter int N_RO          = N_RO_DEFAULT,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT,
  parameter int WINDOW_CYCLES = WINDOW_CYCLES_DEFAULT,
  parameter int CNT_W         = CNT_W_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      continuous,
  input  logic                      abort,
  input  logic [N_RO-1:0]           ro_mask,
  input  logic [CNT_W-1:0]          cnt_value,
  input  logic                      res_ready,
  output logic [N_RO-1:0]           ro_en,
  output logic                      cnt_clear,
  output logic                      cnt_en,
  output logic                      res_valid,
  output logic [$clog2(N_RO)-1:0]   res_idx,
  output logic [CNT_W-1:0]          res_count,
  output logic                      busy,
  output logic                      scan_done
);

  localparam int IDX_W = $clog2(N_RO);

  state_e             state, state_d;
  logic [TIMER_W-1:0] timer;
  logic [IDX_W-1:0]   idx, idx_d;
  logic [N_RO-1:0]    scan_mask, mask_d;
  logic               capture;
  logic               nxt_valid;
  logic [IDX_W-1:0]   nxt_idx;

  function automatic logic [IDX_W-1:0] lowest_set(input logic [N_RO-1:0] m);
    lowest_set = '0;
    for (int i = N_RO - 1; i >= 0; i--) begin
      if (m[i]) lowest_set = IDX_W'(i);
    end
  endfunction

  ro_next_index #(
    .N     (N_RO),
    .IDX_W (IDX_W)
  ) u_next (
    .mask     (scan_mask),
    .idx      (idx),
    .valid    (nxt_valid),
    .next_idx (nxt_idx)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d   = state;
    idx_d     = idx;
    mask_d    = scan_mask;
    capture   = 1'b0;
    ro_en     = '0;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;
    res_valid = 1'b0;
    busy      = 1'b1;
    scan_done = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if ((start || continuous) && (ro_mask != '0)) begin
          mask_d  = ro_mask;
          idx_d   = lowest_set(ro_mask);
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        ro_en     = N_RO'(1) << idx;
        cnt_clear = 1'b1;
        if (timer == TIMER_W'(SETTLE_CYCLES - 1)) state_d = ST_GATE;
      end
      ST_GATE: begin
        ro_en  = N_RO'(1) << idx;
        cnt_en = 1'b1;
        if (timer == TIMER_W'(WINDOW_CYCLES - 1)) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        ro_en   = N_RO'(1) << idx;
        capture = 1'b1;
        state_d = ST_REPORT;
      end
      ST_REPORT: begin
        res_valid = 1'b1;
        if (res_ready) state_d = ST_NEXT;
      end
      ST_NEXT: begin
        if (nxt_valid) begin
          idx_d   = nxt_idx;
          state_d = ST_SETTLE;
        end else begin
          scan_done = 1'b1;
          if (continuous && (ro_mask != '0)) begin
            mask_d  = ro_mask;
            idx_d   = lowest_set(ro_mask);
            state_d = ST_SETTLE;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  // Abort also clears the result registers so IDLE presents all outputs low.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer     <= '0;
      idx       <= '0;
      scan_mask <= '0;
      res_idx   <= '0;
      res_count <= '0;
    end else begin
      timer     <= (state_d != state) ? '0 : timer + 1'b1;
      idx       <= idx_d;
      scan_mask <= mask_d;
      if (abort) begin
        res_idx   <= '0;
        res_count <= '0;
      end else if (capture) begin
        res_idx   <= idx;
        res_count <= cnt_value;
      end
    end
  end

endmodule

// File: tb/tb_ro_scan_scheduler.sv
// Directed bench for ro_scan_scheduler at default parameters.
module tb_ro_scan_scheduler;

  localparam int LAT = 16 + 1024 + 1;

  logic        clk = 1'b0;
  logic        reset, start, continuous, abort, res_ready;
  logic [3:0]  ro_mask;
  logic [23:0] cnt_value;
  logic [3:0]  ro_en;
  logic        cnt_clear, cnt_en, res_valid, busy, scan_done;
  logic [1:0]  res_idx;
  logic [23:0] res_count;

  int vectors     = 0;
  int miscompares = 0;

  ro_scan_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .continuous (continuous),
    .abort      (abort),
    .ro_mask    (ro_mask),
    .cnt_value  (cnt_value),
    .res_ready  (res_ready),
    .ro_en      (ro_en),
    .cnt_clear  (cnt_clear),
    .cnt_en     (cnt_en),
    .res_valid  (res_valid),
    .res_idx    (res_idx),
    .res_count  (res_count),
    .busy       (busy),
    .scan_done  (scan_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      assert ($countones(ro_en) <= 1) else begin
        miscompares++;
        $error("FAIL ro_en_onehot observed=%b expected=onehot_or_zero", ro_en);
      end
      assert (!(cnt_en && cnt_clear)) else begin
        miscompares++;
        $error("FAIL en_clear_excl observed=%b%b expected=not_both", cnt_en, cnt_clear);
      end
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called in SETTLE/GATE, 'pre' cycles after SETTLE entry; returns in REPORT.
  task automatic run_osc(input string tag, input int exp_idx, input logic [23:0] exp_cnt,
                         input int pre);
    int n;
    logic [3:0] oh;
    oh = 4'b0001 << exp_idx;
    check({tag, "_ro_en"}, 32'(ro_en), 32'(oh));
    n = 0;
    while (res_valid !== 1'b1 && n < 5000) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 32'(pre + n), 32'(LAT));
    check({tag, "_idx"}, 32'(res_idx), 32'(exp_idx));
    check({tag, "_count"}, 32'(res_count), 32'(exp_cnt));
    check({tag, "_ro_off"}, 32'(ro_en), 32'h0);
  endtask

  initial begin
    int stable;
    int seen;
    reset = 1'b1; start = 1'b0; continuous = 1'b0; abort = 1'b0;
    res_ready = 1'b0; ro_mask = 4'b0000; cnt_value = 24'h0;
    tick(2);
    reset = 1'b0;
    tick();
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_ro_en", 32'(ro_en), 32'h0);
    check("rst_cnt", 32'({cnt_en, cnt_clear}), 32'h0);
    check("rst_res", 32'({res_valid, scan_done, res_idx}), 32'h0);
    check("rst_count", 32'(res_count), 32'h0);

    // Mask 1011, consumer always ready: idx 0, 1, 3 then one scan_done.
    ro_mask = 4'b1011; res_ready = 1'b1; cnt_value = 24'h000123; start = 1'b1;
    tick();
    start = 1'b0;
    check("s1_settle_busy", 32'(busy), 32'h1);
    check("s1_settle_clear", 32'({cnt_clear, cnt_en}), 32'h2);
    tick(16);
    check("s1_gate_en", 32'({cnt_clear, cnt_en}), 32'h1);
    run_osc("s1_o0", 0, 24'h000123, 16);
    tick();
    check("s1_next0_done", 32'({busy, scan_done}), 32'h2);
    tick();
    run_osc("s1_o1", 1, 24'h000123, 0);
    tick(2);
    run_osc("s1_o3", 3, 24'h000123, 0);
    tick();
    check("s1_done_pulse", 32'({busy, scan_done}), 32'h3);
    tick();
    check("s1_idle", 32'({busy, scan_done, res_valid}), 32'h0);

    // Back-pressure: result held stable while res_ready is low.
    ro_mask = 4'b0001; res_ready = 1'b0; cnt_value = 24'h00ABCD; start = 1'b1;
    tick();
    start = 1'b0;
    run_osc("s2", 0, 24'h00ABCD, 0);
    cnt_value = 24'h111111;
    stable = 0;
    for (int i = 0; i < 50; i++) begin
      if (res_valid === 1'b1 && res_idx === 2'd0 && res_count === 24'h00ABCD) stable++;
      tick();
    end
    check("s2_stable_cycles", 32'(stable), 32'd50);
    check("s2_still_valid", 32'(res_valid), 32'h1);
    res_ready = 1'b1;
    tick();
    check("s2_next", 32'({busy, res_valid, scan_done}), 32'h5);
    tick();
    check("s2_idle", 32'(busy), 32'h0);

    // Empty mask is ignored; start and mask changes mid-scan are ignored.
    ro_mask = 4'b0000; start = 1'b1;
    tick();
    start = 1'b0;
    check("s3_empty_busy", 32'({busy, ro_en}), 32'h0);
    ro_mask = 4'b0010; cnt_value = 24'h0055AA; start = 1'b1;
    tick();
    start = 1'b0;
    tick(5);
    ro_mask = 4'b1111; start = 1'b1;
    tick();
    start = 1'b0;
    run_osc("s3", 1, 24'h0055AA, 6);
    tick();
    check("s3_done", 32'({busy, scan_done}), 32'h3);
    tick();
    check("s3_no_restart", 32'(busy), 32'h0);

    // Abort 500 cycles into GATE.
    ro_mask = 4'b0001; start = 1'b1;
    tick();
    start = 1'b0;
    tick(16 + 500);
    check("s4_in_gate", 32'(cnt_en), 32'h1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("s4_abort_outs", 32'({busy, cnt_en, cnt_clear, res_valid, ro_en}), 32'h0);
    check("s4_abort_count", 32'(res_count), 32'h0);
    seen = 0;
    for (int i = 0; i < 1100; i++) begin
      if (res_valid !== 1'b0 || busy !== 1'b0) seen++;
      tick();
    end
    check("s4_no_result", 32'(seen), 32'h0);

    // Continuous rescan of idx 2; dropping continuous ends after the scan.
    ro_mask = 4'b0100; continuous = 1'b1; cnt_value = 24'h000777;
    tick();
    run_osc("s5_a", 2, 24'h000777, 0);
    tick();
    check("s5_done_a", 32'({busy, scan_done}), 32'h3);
    tick();
    check("s5_rescan", 32'({busy, ro_en}), 32'h14);
    continuous = 1'b0;
    run_osc("s5_b", 2, 24'h000777, 0);
    tick();
    check("s5_done_b", 32'({busy, scan_done}), 32'h3);
    tick(2);
    check("s5_idle", 32'({busy, scan_done}), 32'h0);

    // Reset while a result is pending discards it.
    res_ready = 1'b0; ro_mask = 4'b1000; cnt_value = 24'h000042; start = 1'b1;
    tick();
    start = 1'b0;
    run_osc("s6", 3, 24'h000042, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("s6_reset_outs", 32'({busy, res_valid, res_idx}), 32'h0);
    check("s6_reset_count", 32'(res_count), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ro_scan_scheduler.md
RO_SCAN_SCHEDULER -- requirements
Module: ro_scan_scheduler

Interface
REQ-001 Parameter N_RO, default 4: number of ring oscillators scanned.
REQ-002 Parameter SETTLE_CYCLES, default 16: oscillator warm-up cycles before gating.
REQ-003 Parameter WINDOW_CYCLES, default 1024: counter gate length in clk cycles.
REQ-004 Parameter CNT_W, default 24: count width.
REQ-005 Reset is reset, synchronous, active-high; the clock is clk.
REQ-006 The ports SHALL be, in order:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- start  in  1  single-cycle scan request
- continuous  in  1  level; rescan after each completed scan
- abort  in  1  stop immediately
- ro_mask  in  N_RO  oscillators to include in the scan
- cnt_value  in  CNT_W  shared edge-counter output
- res_ready  in  1  consumer (UART framer) accepts the result
- ro_en  out  N_RO  one-hot oscillator enable
- cnt_clear  out  1  shared counter clear
- cnt_en  out  1  shared counter gate
- res_valid  out  1  result available
- res_idx  out  clog2(N_RO)  oscillator index of the result
- res_count  out  CNT_W  captured count
- busy  out  1  scan in progress
- scan_done  out  1  one-cycle pulse at scan end

Function
REQ-007 The FSM SHALL have the states IDLE, SETTLE, GATE, CAPTURE, REPORT and NEXT, and a 16-bit phase timer that clears on every state change.
REQ-008 In IDLE, start=1 or continuous=1 with ro_mask!=0 SHALL latch ro_mask into scan_mask, set idx to the lowest set bit and go to SETTLE; with ro_mask==0 the FSM SHALL stay in IDLE.
REQ-009 SETTLE SHALL drive ro_en=onehot(idx) and cnt_clear=1 for exactly SETTLE_CYCLES cycles, then go to GATE.
REQ-010 GATE SHALL drive ro_en=onehot(idx) and cnt_en=1 for exactly WINDOW_CYCLES cycles, then go to CAPTURE.
REQ-011 CAPTURE (1 cycle) SHALL drive ro_en=onehot(idx) and cnt_en=0, register cnt_value into res_count and idx into res_idx, then go to REPORT.
REQ-012 REPORT SHALL drive ro_en=0 and hold res_valid=1 with res_idx and res_count stable until res_valid&res_ready; on that handshake cycle it SHALL go to NEXT.
REQ-013 NEXT (1 cycle) SHALL select the lowest set bit of scan_mask above idx and go to SETTLE; if none exists it SHALL pulse scan_done and go to SETTLE with the lowest set bit when continuous=1 (scan_mask re-latched from ro_mask, or IDLE if ro_mask==0), else to IDLE.
REQ-014 start while busy SHALL be ignored; ro_mask changes mid-scan SHALL have no effect until the next scan.
REQ-015 abort=1 in any state SHALL move the FSM to IDLE at the next edge with every output deasserted; abort has priority over res_ready and start.
REQ-016 busy SHALL be 1 in every state except IDLE.
REQ-017 At most one ro_en bit SHALL ever be high; cnt_en and cnt_clear SHALL never both be high.
REQ-018 Per-oscillator latency from entry into SETTLE to res_valid SHALL be SETTLE_CYCLES+WINDOW_CYCLES+1 cycles.

Reset
REQ-019 Reset SHALL force IDLE and set timer=0, idx=0, scan_mask=0, ro_en=0, cnt_clear=0, cnt_en=0, res_valid=0, res_idx=0, res_count=0, busy=0 and scan_done=0; reset mid-scan discards the pending result.

Structure
REQ-020 The state encoding and the default N_RO, SETTLE_CYCLES, WINDOW_CYCLES and CNT_W SHALL live in the shared package ro_sched_pkg.
REQ-021 The next-set-bit search SHALL be a combinational sub-module ro_next_index, with inputs mask and idx and outputs valid and next_idx.

Verification
REQ-022 Mask 4'b1011, start pulse, res_ready tied to 1 -> three results with idx 0, 1, 3, each after 16+1024+1 cycles, then one scan_done and IDLE.
REQ-023 cnt_value=24'h00ABCD during CAPTURE and res_ready held low for 50 cycles -> res_valid, res_idx and res_count=0x00ABCD stay stable for 50 cycles; NEXT follows the handshake cycle.
REQ-024 ro_mask=0 with start, and start pulsed again mid-scan -> no state change from the first and no restart from the second.
REQ-025 abort during GATE at cycle 500 -> IDLE next cycle with ro_en=0, cnt_en=0 and busy=0, and no res_valid.
REQ-026 continuous=1 with mask 4'b0100 -> idx 2 repeats with a scan_done pulse between scans; dropping continuous ends after the current scan.
REQ-027 Assertions throughout: ro_en one-hot or zero, and never cnt_en&cnt_clear.
